// File: rtl/nvdla_axi_mem_arbiter.sv
// nvdla_axi_mem_arbiter: merges the NVDLA dbb (s0) and cvsram (s1) AXI4
// ports onto one downstream port. AR/AW are round-robin arbitrated into
// single-entry register slices; W bursts follow AW grant order through a
// small source FIFO; R/B are routed back by the ID bit prepended at grant.
module nvdla_axi_mem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 256,
  parameter int ID_W     = 8,
  parameter int WQ_DEPTH = 4
) (
  input  logic                core_clk,
  input  logic                rst,
  // s0 (dbb)
  input  logic                s0_ar_arvalid,
  input  logic [ID_W-1:0]     s0_ar_arid,
  input  logic [3:0]          s0_ar_arlen,
  input  logic [2:0]          s0_ar_arsize,
  input  logic [ADDR_W-1:0]   s0_ar_araddr,
  output logic                s0_ar_arready,
  input  logic                s0_aw_awvalid,
  input  logic [ID_W-1:0]     s0_aw_awid,
  input  logic [3:0]          s0_aw_awlen,
  input  logic [2:0]          s0_aw_awsize,
  input  logic [ADDR_W-1:0]   s0_aw_awaddr,
  output logic                s0_aw_awready,
  input  logic                s0_w_wvalid,
  input  logic [DATA_W-1:0]   s0_w_wdata,
  input  logic [DATA_W/8-1:0] s0_w_wstrb,
  input  logic                s0_w_wlast,
  output logic                s0_w_wready,
  output logic                s0_r_rvalid,
  output logic [ID_W-1:0]     s0_r_rid,
  output logic                s0_r_rlast,
  output logic [DATA_W-1:0]   s0_r_rdata,
  input  logic                s0_r_rready,
  output logic                s0_b_bvalid,
  output logic [ID_W-1:0]     s0_b_bid,
  input  logic                s0_b_bready,
  // s1 (cvsram)
  input  logic                s1_ar_arvalid,
  input  logic [ID_W-1:0]     s1_ar_arid,
  input  logic [3:0]          s1_ar_arlen,
  input  logic [2:0]          s1_ar_arsize,
  input  logic [ADDR_W-1:0]   s1_ar_araddr,
  output logic                s1_ar_arready,
  input  logic                s1_aw_awvalid,
  input  logic [ID_W-1:0]     s1_aw_awid,
  input  logic [3:0]          s1_aw_awlen,
  input  logic [2:0]          s1_aw_awsize,
  input  logic [ADDR_W-1:0]   s1_aw_awaddr,
  output logic                s1_aw_awready,
  input  logic                s1_w_wvalid,
  input  logic [DATA_W-1:0]   s1_w_wdata,
  input  logic [DATA_W/8-1:0] s1_w_wstrb,
  input  logic                s1_w_wlast,
  output logic                s1_w_wready,
  output logic                s1_r_rvalid,
  output logic [ID_W-1:0]     s1_r_rid,
  output logic                s1_r_rlast,
  output logic [DATA_W-1:0]   s1_r_rdata,
  input  logic                s1_r_rready,
  output logic                s1_b_bvalid,
  output logic [ID_W-1:0]     s1_b_bid,
  input  logic                s1_b_bready,
  // downstream
  output logic                m_ar_arvalid,
  output logic [ID_W:0]       m_ar_arid,
  output logic [3:0]          m_ar_arlen,
  output logic [2:0]          m_ar_arsize,
  output logic [ADDR_W-1:0]   m_ar_araddr,
  input  logic                m_ar_arready,
  output logic                m_aw_awvalid,
  output logic [ID_W:0]       m_aw_awid,
  output logic [3:0]          m_aw_awlen,
  output logic [2:0]          m_aw_awsize,
  output logic [ADDR_W-1:0]   m_aw_awaddr,
  input  logic                m_aw_awready,
  output logic                m_w_wvalid,
  output logic [DATA_W-1:0]   m_w_wdata,
  output logic [DATA_W/8-1:0] m_w_wstrb,
  output logic                m_w_wlast,
  input  logic                m_w_wready,
  input  logic                m_r_rvalid,
  input  logic [ID_W:0]       m_r_rid,
  input  logic                m_r_rlast,
  input  logic [DATA_W-1:0]   m_r_rdata,
  output logic                m_r_rready,
  input  logic                m_b_bvalid,
  input  logic [ID_W:0]       m_b_bid,
  output logic                m_b_bready
);

  localparam int QP_W = $clog2(WQ_DEPTH);
  localparam logic [QP_W:0]   CNT_FULL = (QP_W+1)'(WQ_DEPTH);
  localparam logic [QP_W:0]   CNT_ONE  = (QP_W+1)'(1);
  localparam logic [QP_W-1:0] PTR_ONE  = QP_W'(1);

  // AR slice
  logic              ar_v_q, ar_v_d;
  logic [ID_W:0]     ar_id_q, ar_id_d;
  logic [3:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              last_ar_q, last_ar_d;
  logic              ar_free, ar_g0, ar_g1;

  // AW slice
  logic              aw_v_q, aw_v_d;
  logic [ID_W:0]     aw_id_q, aw_id_d;
  logic [3:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              last_aw_q, last_aw_d;
  logic              aw_free, aw_g0, aw_g1;

  // W-order FIFO of source bits
  logic [WQ_DEPTH-1:0] wq_q, wq_d;
  logic [QP_W-1:0]     wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
  logic [QP_W:0]       wq_cnt_q, wq_cnt_d;
  logic                wq_full, wq_empty, wq_head, wq_push, wq_pop;

  // AR grant: round-robin on ties, only when the slice can take a new entry
  always_comb begin
    ar_free = !ar_v_q || m_ar_arready;
    ar_g0   = !rst && ar_free && s0_ar_arvalid && (!s1_ar_arvalid || last_ar_q);
    ar_g1   = !rst && ar_free && s1_ar_arvalid && (!s0_ar_arvalid || !last_ar_q);
    s0_ar_arready = ar_g0;
    s1_ar_arready = ar_g1;
    ar_v_d    = ar_v_q;
    ar_id_d   = ar_id_q;
    ar_len_d  = ar_len_q;
    ar_size_d = ar_size_q;
    ar_addr_d = ar_addr_q;
    last_ar_d = last_ar_q;
    if (ar_g0) begin
      ar_v_d    = 1'b1;
      ar_id_d   = {1'b0, s0_ar_arid};
      ar_len_d  = s0_ar_arlen;
      ar_size_d = s0_ar_arsize;
      ar_addr_d = s0_ar_araddr;
      last_ar_d = 1'b0;
    end else if (ar_g1) begin
      ar_v_d    = 1'b1;
      ar_id_d   = {1'b1, s1_ar_arid};
      ar_len_d  = s1_ar_arlen;
      ar_size_d = s1_ar_arsize;
      ar_addr_d = s1_ar_araddr;
      last_ar_d = 1'b1;
    end else if (m_ar_arready) begin
      ar_v_d = 1'b0;
    end
  end

  // AW grant: as AR, but also blocked while the W-order FIFO is full
  always_comb begin
    aw_free = !aw_v_q || m_aw_awready;
    aw_g0   = !rst && !wq_full && aw_free && s0_aw_awvalid && (!s1_aw_awvalid || last_aw_q);
    aw_g1   = !rst && !wq_full && aw_free && s1_aw_awvalid && (!s0_aw_awvalid || !last_aw_q);
    s0_aw_awready = aw_g0;
    s1_aw_awready = aw_g1;
    aw_v_d    = aw_v_q;
    aw_id_d   = aw_id_q;
    aw_len_d  = aw_len_q;
    aw_size_d = aw_size_q;
    aw_addr_d = aw_addr_q;
    last_aw_d = last_aw_q;
    if (aw_g0) begin
      aw_v_d    = 1'b1;
      aw_id_d   = {1'b0, s0_aw_awid};
      aw_len_d  = s0_aw_awlen;
      aw_size_d = s0_aw_awsize;
      aw_addr_d = s0_aw_awaddr;
      last_aw_d = 1'b0;
    end else if (aw_g1) begin
      aw_v_d    = 1'b1;
      aw_id_d   = {1'b1, s1_aw_awid};
      aw_len_d  = s1_aw_awlen;
      aw_size_d = s1_aw_awsize;
      aw_addr_d = s1_aw_awaddr;
      last_aw_d = 1'b1;
    end else if (m_aw_awready) begin
      aw_v_d = 1'b0;
    end
  end

  // W mux: the FIFO head picks which source's burst goes downstream
  always_comb begin
    wq_full  = (wq_cnt_q == CNT_FULL);
    wq_empty = (wq_cnt_q == '0);
    wq_head  = wq_q[wq_rd_q];
    m_w_wvalid  = 1'b0;
    m_w_wdata   = wq_head ? s1_w_wdata : s0_w_wdata;
    m_w_wstrb   = wq_head ? s1_w_wstrb : s0_w_wstrb;
    m_w_wlast   = wq_head ? s1_w_wlast : s0_w_wlast;
    s0_w_wready = 1'b0;
    s1_w_wready = 1'b0;
    if (!rst && !wq_empty) begin
      m_w_wvalid = wq_head ? s1_w_wvalid : s0_w_wvalid;
      if (wq_head) s1_w_wready = m_w_wready;
      else         s0_w_wready = m_w_wready;
    end
    wq_pop  = m_w_wvalid && m_w_wready && m_w_wlast;
    wq_push = aw_g0 || aw_g1;
  end

  // W-order FIFO next state; simultaneous push and pop keep occupancy
  always_comb begin
    wq_d     = wq_q;
    wq_wr_d  = wq_wr_q;
    wq_rd_d  = wq_rd_q;
    wq_cnt_d = wq_cnt_q;
    if (wq_push) begin
      wq_d[wq_wr_q] = aw_g1;
      wq_wr_d       = wq_wr_q + PTR_ONE;
    end
    if (wq_pop) wq_rd_d = wq_rd_q + PTR_ONE;
    case ({wq_push, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + CNT_ONE;
      2'b01:   wq_cnt_d = wq_cnt_q - CNT_ONE;
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  // State registers; reset empties both slices and the FIFO, s0 wins first tie
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      ar_v_q    <= 1'b0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      ar_addr_q <= '0;
      last_ar_q <= 1'b1;
      aw_v_q    <= 1'b0;
      aw_id_q   <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      aw_addr_q <= '0;
      last_aw_q <= 1'b1;
      wq_q      <= '0;
      wq_wr_q   <= '0;
      wq_rd_q   <= '0;
      wq_cnt_q  <= '0;
    end else begin
      ar_v_q    <= ar_v_d;
      ar_id_q   <= ar_id_d;
      ar_len_q  <= ar_len_d;
      ar_size_q <= ar_size_d;
      ar_addr_q <= ar_addr_d;
      last_ar_q <= last_ar_d;
      aw_v_q    <= aw_v_d;
      aw_id_q   <= aw_id_d;
      aw_len_q  <= aw_len_d;
      aw_size_q <= aw_size_d;
      aw_addr_q <= aw_addr_d;
      last_aw_q <= last_aw_d;
      wq_q      <= wq_d;
      wq_wr_q   <= wq_wr_d;
      wq_rd_q   <= wq_rd_d;
      wq_cnt_q  <= wq_cnt_d;
    end
  end

  // Slice outputs
  always_comb begin
    m_ar_arvalid = ar_v_q;
    m_ar_arid    = ar_id_q;
    m_ar_arlen   = ar_len_q;
    m_ar_arsize  = ar_size_q;
    m_ar_araddr  = ar_addr_q;
    m_aw_awvalid = aw_v_q;
    m_aw_awid    = aw_id_q;
    m_aw_awlen   = aw_len_q;
    m_aw_awsize  = aw_size_q;
    m_aw_awaddr  = aw_addr_q;
  end

  // R/B return path: route on the prepended source bit, purely combinational
  always_comb begin
    s0_r_rvalid = m_r_rvalid && !m_r_rid[ID_W];
    s1_r_rvalid = m_r_rvalid &&  m_r_rid[ID_W];
    s0_r_rid    = m_r_rid[ID_W-1:0];
    s1_r_rid    = m_r_rid[ID_W-1:0];
    s0_r_rlast  = m_r_rlast;
    s1_r_rlast  = m_r_rlast;
    s0_r_rdata  = m_r_rdata;
    s1_r_rdata  = m_r_rdata;
    m_r_rready  = m_r_rid[ID_W] ? s1_r_rready : s0_r_rready;
    s0_b_bvalid = m_b_bvalid && !m_b_bid[ID_W];
    s1_b_bvalid = m_b_bvalid &&  m_b_bid[ID_W];
    s0_b_bid    = m_b_bid[ID_W-1:0];
    s1_b_bid    = m_b_bid[ID_W-1:0];
    m_b_bready  = m_b_bid[ID_W] ? s1_b_bready : s0_b_bready;
  end

endmodule

// File: tb/tb_nvdla_axi_mem_arbiter.sv
// Bench for nvdla_axi_mem_arbiter: a queue-based transaction model checks
// every cycle at the falling edge, and directed scenarios pin literal values.
module tb_nvdla_axi_mem_arbiter;
  localparam int AW = 64, DW = 256, IW = 8, WQD = 4;

  logic core_clk = 1'b0;
  logic rst = 1'b1;
  logic s0_ar_arvalid, s0_ar_arready, s1_ar_arvalid, s1_ar_arready;
  logic [IW-1:0] s0_ar_arid, s1_ar_arid, s0_aw_awid, s1_aw_awid;
  logic [3:0] s0_ar_arlen, s1_ar_arlen, s0_aw_awlen, s1_aw_awlen, m_ar_arlen, m_aw_awlen;
  logic [2:0] s0_ar_arsize, s1_ar_arsize, s0_aw_awsize, s1_aw_awsize, m_ar_arsize, m_aw_awsize;
  logic [AW-1:0] s0_ar_araddr, s1_ar_araddr, s0_aw_awaddr, s1_aw_awaddr, m_ar_araddr, m_aw_awaddr;
  logic s0_aw_awvalid, s0_aw_awready, s1_aw_awvalid, s1_aw_awready;
  logic s0_w_wvalid, s0_w_wlast, s0_w_wready, s1_w_wvalid, s1_w_wlast, s1_w_wready;
  logic [DW-1:0] s0_w_wdata, s1_w_wdata, m_w_wdata, s0_r_rdata, s1_r_rdata, m_r_rdata;
  logic [DW/8-1:0] s0_w_wstrb, s1_w_wstrb, m_w_wstrb;
  logic s0_r_rvalid, s0_r_rlast, s0_r_rready, s1_r_rvalid, s1_r_rlast, s1_r_rready;
  logic [IW-1:0] s0_r_rid, s1_r_rid, s0_b_bid, s1_b_bid;
  logic s0_b_bvalid, s0_b_bready, s1_b_bvalid, s1_b_bready;
  logic m_ar_arvalid, m_ar_arready, m_aw_awvalid, m_aw_awready;
  logic [IW:0] m_ar_arid, m_aw_awid, m_r_rid, m_b_bid;
  logic m_w_wvalid, m_w_wlast, m_w_wready;
  logic m_r_rvalid, m_r_rlast, m_r_rready, m_b_bvalid, m_b_bready;

  nvdla_axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .WQ_DEPTH(WQD)) dut (
    .core_clk(core_clk), .rst(rst),
    .s0_ar_arvalid(s0_ar_arvalid), .s0_ar_arid(s0_ar_arid), .s0_ar_arlen(s0_ar_arlen),
    .s0_ar_arsize(s0_ar_arsize), .s0_ar_araddr(s0_ar_araddr), .s0_ar_arready(s0_ar_arready),
    .s0_aw_awvalid(s0_aw_awvalid), .s0_aw_awid(s0_aw_awid), .s0_aw_awlen(s0_aw_awlen),
    .s0_aw_awsize(s0_aw_awsize), .s0_aw_awaddr(s0_aw_awaddr), .s0_aw_awready(s0_aw_awready),
    .s0_w_wvalid(s0_w_wvalid), .s0_w_wdata(s0_w_wdata), .s0_w_wstrb(s0_w_wstrb),
    .s0_w_wlast(s0_w_wlast), .s0_w_wready(s0_w_wready),
    .s0_r_rvalid(s0_r_rvalid), .s0_r_rid(s0_r_rid), .s0_r_rlast(s0_r_rlast),
    .s0_r_rdata(s0_r_rdata), .s0_r_rready(s0_r_rready),
    .s0_b_bvalid(s0_b_bvalid), .s0_b_bid(s0_b_bid), .s0_b_bready(s0_b_bready),
    .s1_ar_arvalid(s1_ar_arvalid), .s1_ar_arid(s1_ar_arid), .s1_ar_arlen(s1_ar_arlen),
    .s1_ar_arsize(s1_ar_arsize), .s1_ar_araddr(s1_ar_araddr), .s1_ar_arready(s1_ar_arready),
    .s1_aw_awvalid(s1_aw_awvalid), .s1_aw_awid(s1_aw_awid), .s1_aw_awlen(s1_aw_awlen),
    .s1_aw_awsize(s1_aw_awsize), .s1_aw_awaddr(s1_aw_awaddr), .s1_aw_awready(s1_aw_awready),
    .s1_w_wvalid(s1_w_wvalid), .s1_w_wdata(s1_w_wdata), .s1_w_wstrb(s1_w_wstrb),
    .s1_w_wlast(s1_w_wlast), .s1_w_wready(s1_w_wready),
    .s1_r_rvalid(s1_r_rvalid), .s1_r_rid(s1_r_rid), .s1_r_rlast(s1_r_rlast),
    .s1_r_rdata(s1_r_rdata), .s1_r_rready(s1_r_rready),
    .s1_b_bvalid(s1_b_bvalid), .s1_b_bid(s1_b_bid), .s1_b_bready(s1_b_bready),
    .m_ar_arvalid(m_ar_arvalid), .m_ar_arid(m_ar_arid), .m_ar_arlen(m_ar_arlen),
    .m_ar_arsize(m_ar_arsize), .m_ar_araddr(m_ar_araddr), .m_ar_arready(m_ar_arready),
    .m_aw_awvalid(m_aw_awvalid), .m_aw_awid(m_aw_awid), .m_aw_awlen(m_aw_awlen),
    .m_aw_awsize(m_aw_awsize), .m_aw_awaddr(m_aw_awaddr), .m_aw_awready(m_aw_awready),
    .m_w_wvalid(m_w_wvalid), .m_w_wdata(m_w_wdata), .m_w_wstrb(m_w_wstrb),
    .m_w_wlast(m_w_wlast), .m_w_wready(m_w_wready),
    .m_r_rvalid(m_r_rvalid), .m_r_rid(m_r_rid), .m_r_rlast(m_r_rlast),
    .m_r_rdata(m_r_rdata), .m_r_rready(m_r_rready),
    .m_b_bvalid(m_b_bvalid), .m_b_bid(m_b_bid), .m_b_bready(m_b_bready)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct packed {
    logic [IW:0]   id;
    logic [3:0]    len;
    logic [2:0]    size;
    logic [AW-1:0] addr;
  } ax_t;

  bit  ar_v = 0, aw_v = 0, last_ar = 1, last_aw = 1;
  ax_t ar_s, aw_s;
  int  wq[$];
  bit  ar_v_n = 0, aw_v_n = 0, last_ar_n = 1, last_aw_n = 1;
  ax_t ar_s_n, aw_s_n;
  int  wq_n[$];

  // Per-cycle comparison against the model, then model next-state
  always @(negedge core_clk) begin : model_chk
    bit free, g0, g1, ev, el, pop;
    int h;
    chk("s0_rvalid", s0_r_rvalid, m_r_rvalid && (m_r_rid[IW] == 1'b0));
    chk("s1_rvalid", s1_r_rvalid, m_r_rvalid && (m_r_rid[IW] == 1'b1));
    chk("s0_rid", s0_r_rid, m_r_rid % 256);
    chk("s1_rdata", s1_r_rdata, m_r_rdata);
    chk("s0_rlast", s0_r_rlast, m_r_rlast);
    chk("m_rready", m_r_rready, (m_r_rid >= 256) ? s1_r_rready : s0_r_rready);
    chk("s0_bvalid", s0_b_bvalid, m_b_bvalid && (m_b_bid < 256));
    chk("s1_bvalid", s1_b_bvalid, m_b_bvalid && (m_b_bid >= 256));
    chk("s1_bid", s1_b_bid, m_b_bid % 256);
    chk("m_bready", m_b_bready, (m_b_bid >= 256) ? s1_b_bready : s0_b_bready);
    if (rst) begin
      chk("rst_s0_arready", s0_ar_arready, 0);
      chk("rst_s1_arready", s1_ar_arready, 0);
      chk("rst_s0_awready", s0_aw_awready, 0);
      chk("rst_s1_awready", s1_aw_awready, 0);
      chk("rst_s0_wready", s0_w_wready, 0);
      chk("rst_s1_wready", s1_w_wready, 0);
      chk("rst_m_arvalid", m_ar_arvalid, 0);
      chk("rst_m_awvalid", m_aw_awvalid, 0);
      chk("rst_m_wvalid", m_w_wvalid, 0);
      ar_v_n = 0; aw_v_n = 0; last_ar_n = 1; last_aw_n = 1; wq_n = {};
    end else begin
      // read address
      free = !ar_v || m_ar_arready;
      g0 = free && s0_ar_arvalid && !(s1_ar_arvalid && last_ar == 0);
      g1 = free && s1_ar_arvalid && !(s0_ar_arvalid && last_ar == 1);
      chk("s0_arready", s0_ar_arready, g0);
      chk("s1_arready", s1_ar_arready, g1);
      chk("m_arvalid", m_ar_arvalid, ar_v);
      if (ar_v) chk("m_ar_fields", {m_ar_arid, m_ar_arlen, m_ar_arsize, m_ar_araddr}, ar_s);
      ar_v_n = ar_v; ar_s_n = ar_s; last_ar_n = last_ar;
      if (g0) begin
        ar_v_n = 1; last_ar_n = 0;
        ar_s_n = '{id: {1'b0, s0_ar_arid}, len: s0_ar_arlen, size: s0_ar_arsize, addr: s0_ar_araddr};
      end else if (g1) begin
        ar_v_n = 1; last_ar_n = 1;
        ar_s_n = '{id: {1'b1, s1_ar_arid}, len: s1_ar_arlen, size: s1_ar_arsize, addr: s1_ar_araddr};
      end else if (m_ar_arready) ar_v_n = 0;
      // write address
      free = (!aw_v || m_aw_awready) && (wq.size() < WQD);
      g0 = free && s0_aw_awvalid && !(s1_aw_awvalid && last_aw == 0);
      g1 = free && s1_aw_awvalid && !(s0_aw_awvalid && last_aw == 1);
      chk("s0_awready", s0_aw_awready, g0);
      chk("s1_awready", s1_aw_awready, g1);
      chk("m_awvalid", m_aw_awvalid, aw_v);
      if (aw_v) chk("m_aw_fields", {m_aw_awid, m_aw_awlen, m_aw_awsize, m_aw_awaddr}, aw_s);
      aw_v_n = aw_v; aw_s_n = aw_s; last_aw_n = last_aw;
      if (g0) begin
        aw_v_n = 1; last_aw_n = 0;
        aw_s_n = '{id: {1'b0, s0_aw_awid}, len: s0_aw_awlen, size: s0_aw_awsize, addr: s0_aw_awaddr};
      end else if (g1) begin
        aw_v_n = 1; last_aw_n = 1;
        aw_s_n = '{id: {1'b1, s1_aw_awid}, len: s1_aw_awlen, size: s1_aw_awsize, addr: s1_aw_awaddr};
      end else if (m_aw_awready) aw_v_n = 0;
      // write data in AW order
      pop = 0;
      if (wq.size() == 0) begin
        chk("m_wvalid_empty", m_w_wvalid, 0);
        chk("s0_wready_empty", s0_w_wready, 0);
        chk("s1_wready_empty", s1_w_wready, 0);
      end else begin
        h  = wq[0];
        ev = (h == 1) ? s1_w_wvalid : s0_w_wvalid;
        el = (h == 1) ? s1_w_wlast : s0_w_wlast;
        chk("m_wvalid", m_w_wvalid, ev);
        if (ev) begin
          chk("m_wdata", m_w_wdata, (h == 1) ? s1_w_wdata : s0_w_wdata);
          chk("m_wstrb", m_w_wstrb, (h == 1) ? s1_w_wstrb : s0_w_wstrb);
          chk("m_wlast", m_w_wlast, el);
        end
        chk("s0_wready", s0_w_wready, (h == 0) ? m_w_wready : 1'b0);
        chk("s1_wready", s1_w_wready, (h == 1) ? m_w_wready : 1'b0);
        pop = ev && m_w_wready && el;
      end
      wq_n = wq;
      if (pop) void'(wq_n.pop_front());
      if (g0 || g1) wq_n.push_back(g1 ? 1 : 0);
    end
  end

  // Model state update on the clock edge, asynchronous clear on reset
  always @(posedge core_clk or posedge rst) begin
    if (rst) begin
      ar_v = 0; aw_v = 0; last_ar = 1; last_aw = 1; wq = {};
    end else begin
      ar_v = ar_v_n; ar_s = ar_s_n; last_ar = last_ar_n;
      aw_v = aw_v_n; aw_s = aw_s_n; last_aw = last_aw_n;
      wq = wq_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle();
    s0_ar_arvalid = 0; s0_ar_arid = 0; s0_ar_arlen = 0; s0_ar_arsize = 3'd5; s0_ar_araddr = 0;
    s1_ar_arvalid = 0; s1_ar_arid = 0; s1_ar_arlen = 0; s1_ar_arsize = 3'd5; s1_ar_araddr = 0;
    s0_aw_awvalid = 0; s0_aw_awid = 0; s0_aw_awlen = 0; s0_aw_awsize = 3'd5; s0_aw_awaddr = 0;
    s1_aw_awvalid = 0; s1_aw_awid = 0; s1_aw_awlen = 0; s1_aw_awsize = 3'd5; s1_aw_awaddr = 0;
    s0_w_wvalid = 0; s0_w_wdata = 0; s0_w_wstrb = '1; s0_w_wlast = 0;
    s1_w_wvalid = 0; s1_w_wdata = 0; s1_w_wstrb = '1; s1_w_wlast = 0;
    s0_r_rready = 1; s1_r_rready = 1; s0_b_bready = 1; s1_b_bready = 1;
    m_ar_arready = 1; m_aw_awready = 1; m_w_wready = 1;
    m_r_rvalid = 0; m_r_rid = 0; m_r_rlast = 0; m_r_rdata = 0;
    m_b_bvalid = 0; m_b_bid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    logic exp_src [4];
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    idle();
    // Reset state, with a request and a read beat present during reset
    s0_ar_arvalid = 1;
    m_r_rvalid = 1; m_r_rid = 9'h1_3C;
    step(); step();
    #1;
    chk("lit_rst_arready", s0_ar_arready, 0);
    chk("lit_rst_arvalid", m_ar_arvalid, 0);
    chk("lit_rst_r_pass", s1_r_rvalid, 1);
    chk("lit_rst_r_pass_s0", s0_r_rvalid, 0);

    // Single read from s0
    do_reset();
    s0_ar_arvalid = 1; s0_ar_arid = 8'h05; s0_ar_arlen = 4'd3; s0_ar_araddr = 64'h1000;
    #1 chk("lit_rd_arready", s0_ar_arready, 1);
    step();
    s0_ar_arvalid = 0;
    #1;
    chk("lit_rd_arvalid", m_ar_arvalid, 1);
    chk("lit_rd_arid", m_ar_arid, 9'h005);
    chk("lit_rd_araddr", m_ar_araddr, 64'h1000);
    chk("lit_rd_arlen", m_ar_arlen, 4'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      m_r_rvalid = 1; m_r_rid = 9'h005; m_r_rlast = (i == 3); m_r_rdata = DW'(100 + i);
      #1;
      chk("lit_rd_s0_rvalid", s0_r_rvalid, 1);
      chk("lit_rd_s1_rvalid", s1_r_rvalid, 0);
      chk("lit_rd_rid", s0_r_rid, 8'h05);
      chk("lit_rd_rlast", s0_r_rlast, (i == 3));
    end
    step();
    idle();

    // Contention: alternating grants starting with s0
    do_reset();
    s0_ar_arvalid = 1; s0_ar_arid = 8'h0A;
    s1_ar_arvalid = 1; s1_ar_arid = 8'h0B;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_rr_s0_arready", s0_ar_arready, (i % 2) == 0);
      if (i > 0) chk("lit_rr_src", m_ar_arid[IW], exp_src[i-1]);
      step();
    end
    idle();

    // Backpressure: one grant, slice held for 5 cycles
    do_reset();
    m_ar_arready = 0;
    s0_ar_arvalid = 1; s0_ar_arid = 8'h11; s0_ar_araddr = 64'hA000;
    s1_ar_arvalid = 1; s1_ar_arid = 8'h12; s1_ar_araddr = 64'hB000;
    #1;
    chk("lit_bp_s0_grant", s0_ar_arready, 1);
    chk("lit_bp_s1_grant", s1_ar_arready, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk("lit_bp_hold_id", m_ar_arid, 9'h011);
      chk("lit_bp_hold_addr", m_ar_araddr, 64'hA000);
      chk("lit_bp_s0_ready", s0_ar_arready, 0);
      chk("lit_bp_s1_ready", s1_ar_arready, 0);
    end
    m_ar_arready = 1;
    #1 chk("lit_bp_next_s1", s1_ar_arready, 1);
    step();
    s0_ar_arvalid = 0; s1_ar_arvalid = 0;
    #1 chk("lit_bp_next_id", m_ar_arid, 9'h112);
    step();
    idle();

    // W ordering: s1 burst goes first even though s0 data is waiting
    do_reset();
    s1_aw_awvalid = 1; s1_aw_awid = 8'h22; s1_aw_awlen = 4'd1;
    s0_w_wvalid = 1; s0_w_wdata = DW'(256'hA0); s0_w_wlast = 1;
    #1;
    chk("lit_wo_s1_awready", s1_aw_awready, 1);
    chk("lit_wo_s0_wready0", s0_w_wready, 0);
    chk("lit_wo_wvalid0", m_w_wvalid, 0);
    step();
    s1_aw_awvalid = 0;
    s0_aw_awvalid = 1; s0_aw_awid = 8'h33; s0_aw_awlen = 4'd0;
    s1_w_wvalid = 1; s1_w_wdata = DW'(256'hB0); s1_w_wlast = 0;
    #1;
    chk("lit_wo_s0_awready", s0_aw_awready, 1);
    chk("lit_wo_beat0", m_w_wdata, DW'(256'hB0));
    chk("lit_wo_s0_wready1", s0_w_wready, 0);
    chk("lit_wo_s1_wready1", s1_w_wready, 1);
    step();
    s0_aw_awvalid = 0;
    s1_w_wdata = DW'(256'hB1); s1_w_wlast = 1;
    #1;
    chk("lit_wo_beat1", m_w_wdata, DW'(256'hB1));
    chk("lit_wo_beat1_last", m_w_wlast, 1);
    chk("lit_wo_s0_wready2", s0_w_wready, 0);
    step();
    s1_w_wvalid = 0;
    #1;
    chk("lit_wo_beat2", m_w_wdata, DW'(256'hA0));
    chk("lit_wo_s0_wready3", s0_w_wready, 1);
    step();
    s0_w_wvalid = 0;
    #1 chk("lit_wo_drained", m_w_wvalid, 0);
    idle();

    // FIFO full: 5th AW waits until one burst completes
    do_reset();
    m_w_wready = 0;
    s0_aw_awvalid = 1;
    for (int i = 0; i < 4; i++) begin
      s0_aw_awid = 8'(8'h40 + i);
      #1 chk("lit_ff_accept", s0_aw_awready, 1);
      step();
    end
    s0_aw_awid = 8'h44;
    #1 chk("lit_ff_full", s0_aw_awready, 0);
    s0_w_wvalid = 1; s0_w_wlast = 1; s0_w_wdata = DW'(256'h77); m_w_wready = 1;
    #1;
    chk("lit_ff_pop_wvalid", m_w_wvalid, 1);
    chk("lit_ff_still_full", s0_aw_awready, 0);
    step();
    s0_w_wvalid = 0;
    #1 chk("lit_ff_granted", s0_aw_awready, 1);
    step();
    idle();

    // Asynchronous reset in the middle of a W burst
    do_reset();
    m_ar_arready = 0; m_aw_awready = 0; m_w_wready = 0;
    s1_aw_awvalid = 1; s1_aw_awid = 8'h55; s1_aw_awlen = 4'd3;
    s0_ar_arvalid = 1; s0_ar_arid = 8'h66;
    step();
    s1_aw_awvalid = 0; s0_ar_arvalid = 0;
    s1_w_wvalid = 1; s1_w_wlast = 0; s1_w_wdata = DW'(256'h99);
    #1;
    chk("lit_ar_pre_wvalid", m_w_wvalid, 1);
    chk("lit_ar_pre_awvalid", m_aw_awvalid, 1);
    chk("lit_ar_pre_arvalid", m_ar_arvalid, 1);
    rst = 1;
    #1;
    chk("lit_ar_awvalid", m_aw_awvalid, 0);
    chk("lit_ar_arvalid", m_ar_arvalid, 0);
    chk("lit_ar_wvalid", m_w_wvalid, 0);
    chk("lit_ar_wready", s1_w_wready, 0);
    step();
    step();
    rst = 0;
    idle();
    s0_ar_arvalid = 1; s1_ar_arvalid = 1; s0_ar_arid = 8'h01; s1_ar_arid = 8'h02;
    #1;
    chk("lit_ar_tie_s0", s0_ar_arready, 1);
    chk("lit_ar_tie_s1", s1_ar_arready, 0);
    step();
    idle();
    #1 chk("lit_ar_tie_src", m_ar_arid, 9'h001);

    // Mixed traffic checked by the model alone
    for (int n = 0; n < 300; n++) begin
      step();
      s0_ar_arvalid = 1'($urandom_range(0, 1)); s0_ar_arid = 8'($urandom);
      s1_ar_arvalid = 1'($urandom_range(0, 1)); s1_ar_arid = 8'($urandom);
      s0_ar_araddr = {$urandom, $urandom}; s1_ar_arlen = 4'($urandom);
      s0_aw_awvalid = 1'($urandom_range(0, 1)); s0_aw_awid = 8'($urandom);
      s1_aw_awvalid = 1'($urandom_range(0, 1)); s1_aw_awid = 8'($urandom);
      s1_aw_awaddr = {$urandom, $urandom}; s0_aw_awlen = 4'($urandom);
      s0_w_wvalid = 1'($urandom_range(0, 1)); s0_w_wlast = 1'($urandom_range(0, 1));
      s1_w_wvalid = 1'($urandom_range(0, 1)); s1_w_wlast = 1'($urandom_range(0, 1));
      s0_w_wdata = {8{$urandom}}; s1_w_wdata = {8{$urandom}};
      s0_w_wstrb = {$urandom}; s1_w_wstrb = {$urandom};
      m_ar_arready = 1'($urandom_range(0, 1));
      m_aw_awready = 1'($urandom_range(0, 1));
      m_w_wready = 1'($urandom_range(0, 1));
      m_r_rvalid = 1'($urandom_range(0, 1)); m_r_rid = 9'($urandom);
      m_r_rlast = 1'($urandom_range(0, 1)); m_r_rdata = {8{$urandom}};
      m_b_bvalid = 1'($urandom_range(0, 1)); m_b_bid = 9'($urandom);
      s0_r_rready = 1'($urandom_range(0, 1)); s1_r_rready = 1'($urandom_range(0, 1));
      s0_b_bready = 1'($urandom_range(0, 1)); s1_b_bready = 1'($urandom_range(0, 1));
    end
    step();
    idle();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvdla_axi_mem_arbiter.md
# nvdla_axi_mem_arbiter

Two-to-one AXI4 arbiter that merges the NVDLA core's dbb and cvsram memory ports onto one downstream memory port, for SoCs that attach no separate SRAM. Sits between the NVDLA wrapper's dbb/cvsram AXI outputs and the system interconnect. It does round-robin AR/AW arbitration through registered slices and keeps W bursts in AW order with a small order FIFO. It routes R/B responses back by a source bit prepended to the ID.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 256, data width (strobe = DATA_W/8)
- ID_W, 8, upstream ID width; downstream ID is ID_W+1
- WQ_DEPTH, 4, W-order FIFO depth (power of 2, ≥2)

Ports (s0 = dbb, s1 = cvsram, m = downstream):
- core_clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s{0,1}_ar_arvalid/arid/arlen/arsize/araddr  in  1/ID_W/4/3/ADDR_W  upstream read address
- s{0,1}_ar_arready  out  1  read-address accept
- s{0,1}_aw_awvalid/awid/awlen/awsize/awaddr  in  1/ID_W/4/3/ADDR_W  upstream write address
- s{0,1}_aw_awready  out  1  write-address accept
- s{0,1}_w_wvalid/wdata/wstrb/wlast  in  1/DATA_W/DATA_W/8/1  upstream write data
- s{0,1}_w_wready  out  1
- s{0,1}_r_rvalid/rid/rlast/rdata  out  1/ID_W/1/DATA_W  read response
- s{0,1}_r_rready, s{0,1}_b_bready  in  1
- s{0,1}_b_bvalid/bid  out  1/ID_W  write response
- m_ar_arvalid/arid/arlen/arsize/araddr  out  1/ID_W+1/4/3/ADDR_W
- m_ar_arready  in  1
- m_aw_awvalid/awid/awlen/awsize/awaddr  out  1/ID_W+1/4/3/ADDR_W
- m_aw_awready  in  1
- m_w_wvalid/wdata/wstrb/wlast  out  1/DATA_W/DATA_W/8/1
- m_w_wready  in  1
- m_r_rvalid/rid/rlast/rdata  in  1/ID_W+1/1/DATA_W
- m_r_rready, m_b_bready  out  1
- m_b_bvalid/bid  in  1/ID_W+1

## Operation
- AR slice: one register stage. The slice is free when empty or when m_ar_arvalid&&m_ar_arready in the same cycle.
- When the slice is free, grant one requester:
  - only one valid: grant it;
  - both valid: grant the one not granted last.
- s{n}_ar_arready = grant for that requester, combinational from the valids and slice state.
- On grant, load the slice with the fields, arid = {n, s{n}_arid}, and set last_ar = n.
- AW slice: identical, with its own last_aw pointer. Grant additionally requires the W-order FIFO not full. On grant, push n into the FIFO.
- W: if the FIFO is empty, m_w_wvalid=0 and both s_w_wready=0. If the FIFO is non-empty with head h:
  - m_w_* = s{h}_w_*;
  - s{h}_w_wready = m_w_wready; the other source's wready = 0;
  - pop on m_w_wvalid&&m_w_wready&&wlast.
- FIFO push and pop in the same cycle: both take effect, occupancy is unchanged, and pointers wrap modulo WQ_DEPTH.
- R: route by m_r_rid[ID_W]. The selected s_r_rvalid = m_r_rvalid and the other = 0. rid = m_r_rid[ID_W-1:0]. m_r_rready = selected s_r_rready. B: same scheme on bid.
- Arbitration state only: no outstanding-transaction limit, no reordering.

## Timing
- Reset values: m_ar_arvalid=0, m_aw_awvalid=0, W FIFO empty, last_ar=last_aw=1 (s0 wins the first tie).
- With rst asserted, all s_*ready=0, m_w_wvalid=0.
- R/B outputs and m_r_rready/m_b_bready are combinational pass-through, so they follow the inputs even during reset.
- AR/AW latency: accepted at edge k → m_*valid from cycle k+1. Throughput is one per cycle under continuous m_*ready.
- m_*valid and slice contents are held stable until m_*ready (AXI rule).
- W: the first beat of a burst can leave no earlier than the cycle after its AW handshake with the requester. W is combinational, adding no cycles.
- Reset mid-operation: clears asynchronously, and in-flight bursts are discarded. Upstream and downstream are reset together.

## Test plan
- Single read: s0 AR addr 0x1000, id 0x05, len 3 at cycle 0, m_ar_arready=1 → m_ar_arvalid at cycle 1 with arid 0x005; four R beats with rid 0x005 appear on s0 only, rid 0x05, rlast on the 4th.
- Contention: s0 and s1 assert AR every cycle, m_ar_arready=1 → grants alternate s0,s1,s0,s1 starting with s0; m_ar_arid[8] = 0,1,0,1.
- Backpressure: m_ar_arready=0 for 5 cycles with both requesting → exactly one granted; the slice is held unchanged for 5 cycles; both arready=0 during the hold.
- W ordering: AW s1 (len 1) then AW s0 (len 0), with s0 W presented first → m_w carries s1's 2 beats, then s0's beat; s0 wready=0 until s1's wlast is accepted.
- FIFO full: 4 AWs accepted with m_w_wready=0 → the 5th AW gets awready=0. After one wlast handshake, the 5th is granted the following cycle.
- Async reset during burst: assert rst mid-W → m_aw_awvalid, m_ar_arvalid, m_w_wvalid drop immediately. After release, the next tie grants s0.
